led_arbiter: RTL and testbench
==============================

// Module: led_arbiter
// PURPOSE
//  Shares the Fomu RGB LED between N_REQ requesters using fixed priority (index 0 highest).
//  A grant is held for a minimum number of strobes before preemption.
//  Applies per-requester solid/blink patterns.
//  Drives the requested-level inputs of three downstream 46.875 kHz LED frequency limiters (R, G, B).
//  Shares the i_stb strobe from clk_div with those limiters.
// PARAMETERS
//  N_REQ       4       number of requesters (1..8)
//  HOLD        8       min strobes a grant is kept before a higher-priority requester may preempt (0 = none)
//  BLINK_HALF  23_437  strobes per blink half-period (~0.5 s at 46.875 kHz); must be >= 1
// PORTS
//  i_clk    in   1        system clock (48 MHz)
//  i_rst_n  in   1        reset; synchronous, active-low
//  i_stb    in   1        46.875 kHz strobe, 1 i_clk wide
//  i_req    in   N_REQ    per-requester request level
//  i_rgb    in   3*N_REQ  colour {r,g,b} of requester k at [3k+2:3k]
//  i_blink  in   N_REQ    1 = blink colour, 0 = solid
//  o_gnt    out  N_REQ    one-hot grant (all 0 when idle)
//  o_led_r  out  1        requested red level
//  o_led_g  out  1        requested green level
//  o_led_b  out  1        requested blue level
//  o_busy   out  1        1 while any grant is active
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge):
//   - o_gnt=0, o_led_*=0, o_busy=0, state IDLE.
//   - hold_cnt=0, blink_cnt=0, phase=1.
//   - Reset mid-grant drops the grant the same edge.
//  States IDLE, GRANT (o_busy = state==GRANT); all outputs registered.
//  win = lowest set index of i_req.
//  IDLE:
//   - i_req!=0 -> GRANT; o_gnt=onehot(win), hold_cnt=HOLD, blink_cnt=0, phase=1.
//  GRANT, owner g:
//   - i_req[g]=0, others pending -> regrant to win next edge (hold ignored; release is never blocked).
//   - i_req=0 -> IDLE; o_gnt=0, o_led_*=0 next edge.
//   - hold_cnt==0 and win<g -> preempt: o_gnt=onehot(win), reload hold_cnt/blink state as above.
//   - Lower-priority requests never preempt; they wait.
//  Counting:
//   - hold_cnt decrements on i_stb while >0.
//   - blink_cnt counts i_stb 0..BLINK_HALF-1; wrap toggles phase.
//   - A grant change in the same cycle as i_stb wins: counters reload, strobe not counted.
//  LED outputs:
//   - o_led_{r,g,b} <= i_rgb[g] & (i_blink[g] ? phase : 1), sampled live each cycle.
//   - Latency: 1 cycle from grant or input change.
//  Ordering: o_gnt and o_led_* update on the same edge; no cycle shows a new grant with an old colour.
//  Widths: hold_cnt $clog2(HOLD+1) (min 1); blink_cnt $clog2(BLINK_HALF) (min 1); all saturate/wrap exactly at the stated bounds.
// STRUCTURE
//  Shared include led_defs.vh:
//   - state encodings ST_IDLE/ST_GRANT
//   - RGB bit indices
//   - default strobe rate constant (46_875)
//  Sub-module blink_gen (strobe-driven half-period counter + phase; sync clear input).
//  Priority encoder and grant FSM inline.
// TESTING
//  1. Reset: hold i_rst_n=0 with i_req=4'hF -> o_gnt=0, o_led_*=0, o_busy=0; release -> o_gnt=0001 after 1 clk.
//  2. Single req k=2, rgb=3'b101, solid -> o_gnt=0100, r=1 g=0 b=1 next clk; drop req -> all 0, o_busy=0 next clk.
//  3. Preempt with HOLD=8: req2 granted, req0 raised after 3 strobes -> grant stays 0100 until the 8th strobe, 0001 the cycle after.
//  4. Release: req0 granted, req3 pending, req0 drops mid-hold -> o_gnt=1000 next clk.
//  5. Blink with BLINK_HALF=4, rgb=3'b010 -> o_led_g toggles every 4 strobes, starting high at grant.
//  6. Simultaneous: regrant on an i_stb cycle -> hold_cnt=HOLD and phase=1 after the edge; HOLD=0 preempts within 1 clk.

Source files
------------

// File: rtl/led_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_arbiter_pkg : shared encodings for the RGB LED arbiter            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package led_arbiter_pkg;

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  // Bit positions of each colour within a 3-bit {r,g,b} field.
  localparam int c_rgb_r = 2;
  localparam int c_rgb_g = 1;
  localparam int c_rgb_b = 0;

  localparam int c_stb_rate_hz = 46_875;

endpackage
`default_nettype wire

// File: rtl/led_arbiter_blink_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_arbiter_blink_gen : strobe-driven blink half-period counter       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module led_arbiter_blink_gen #(
  parameter int BLINK_HALF = 23_437
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_clr,
  output logic o_phase_nxt
);

  localparam int c_cnt_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLINK_HALF - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_phase;
  logic               w_phase_nxt;

  // Clear beats the strobe so a fresh grant always starts a full lit half.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (i_clr) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b1;
    end else if (i_stb) begin
      if (r_cnt == c_last) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_phase_nxt = w_phase_nxt;

endmodule
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | led_arbiter : fixed-priority RGB LED sharing with hold and blink      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int HOLD       = 8,
  parameter int BLINK_HALF = 23_437
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stb,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [3*N_REQ-1:0] i_rgb,
  input  logic [N_REQ-1:0]   i_blink,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_led_r,
  output logic               o_led_g,
  output logic               o_led_b,
  output logic               o_busy
);

  localparam int c_idx_w  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_hold_w = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_idx_w-1:0]  r_own;
  logic [c_idx_w-1:0]  w_own_nxt;
  logic [c_idx_w-1:0]  w_win;
  logic [c_hold_w-1:0] r_hold;
  logic                w_any;
  logic                w_reload;
  logic                w_blink_clr;
  logic                w_phase_nxt;
  logic                w_lit;
  logic [2:0]          w_rgb_sel;
  logic [2:0]          r_led;
  logic [N_REQ-1:0]    r_gnt;

  always_comb begin
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) w_win = c_idx_w'(k);
    end
  end

  assign w_any = |i_req;

  // Release by the owner is never gated by the hold counter; only preemption is.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_reload    = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_any) begin
          w_state_nxt = c_st_grant;
          w_own_nxt   = w_win;
          w_reload    = 1'b1;
        end
      end
      c_st_grant: begin
        if (!w_any) begin
          w_state_nxt = c_st_idle;
        end else if (!i_req[r_own] || (r_hold == '0 && w_win < r_own)) begin
          w_own_nxt = w_win;
          w_reload  = 1'b1;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (w_reload) begin
      r_hold <= c_hold_w'(HOLD);
    end else if (i_stb && r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  assign w_blink_clr = w_reload || (w_state_nxt == c_st_idle);

  led_arbiter_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stb       (i_stb),
    .i_clr       (w_blink_clr),
    .o_phase_nxt (w_phase_nxt)
  );

  // Colour is taken from the next owner so grant and colour change together.
  assign w_rgb_sel = i_rgb[3*int'(w_own_nxt) +: 3];
  assign w_lit     = !i_blink[w_own_nxt] || w_phase_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= c_st_idle;
      r_own   <= '0;
      r_gnt   <= '0;
      r_led   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      if (w_state_nxt == c_st_grant) begin
        r_gnt <= N_REQ'(1) << w_own_nxt;
        r_led <= w_rgb_sel & {3{w_lit}};
      end else begin
        r_gnt <= '0;
        r_led <= '0;
      end
    end
  end

  assign o_gnt   = r_gnt;
  assign o_led_r = r_led[c_rgb_r];
  assign o_led_g = r_led[c_rgb_g];
  assign o_led_b = r_led[c_rgb_b];
  assign o_busy  = (r_state == c_st_grant);

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_led_arbiter : scoreboard bench, two parameter sets, shared stimulus|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_led_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] led;
    logic       busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] rgb = '0;
  logic [3:0]  blink = '0;

  logic [3:0] gnt0, gnt1;
  logic       r0, g0, b0, busy0;
  logic       r1, g1, b1, busy1;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: owner, remaining hold strobes, strobes since grant.
  int  m_hold_par[2]  = '{8, 0};
  int  m_half_par[2]  = '{4, 1};
  bit  m_busy[2]      = '{0, 0};
  int  m_own[2]       = '{0, 0};
  int  m_hold[2]      = '{0, 0};
  int  m_strobes[2]   = '{0, 0};

  always #5 clk = ~clk;

  led_arbiter #(.N_REQ(4), .HOLD(8), .BLINK_HALF(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_req(req), .i_rgb(rgb),
    .i_blink(blink), .o_gnt(gnt0), .o_led_r(r0), .o_led_g(g0), .o_led_b(b0),
    .o_busy(busy0)
  );

  led_arbiter #(.N_REQ(4), .HOLD(0), .BLINK_HALF(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_req(req), .i_rgb(rgb),
    .i_blink(blink), .o_gnt(gnt1), .o_led_r(r1), .o_led_g(g1), .o_led_b(b1),
    .o_busy(busy1)
  );

  task automatic model(input int n);
    exp_t e;
    int   win;
    bit   change;
    logic [2:0] col;
    win = -1;
    for (int k = 3; k >= 0; k--) if (req[k]) win = k;
    if (!rst_n) begin
      m_busy[n] = 0; m_own[n] = 0; m_hold[n] = 0; m_strobes[n] = 0;
    end else begin
      change = 0;
      if (!m_busy[n]) begin
        if (win >= 0) begin m_busy[n] = 1; m_own[n] = win; change = 1; end
      end else if (win < 0) begin
        m_busy[n] = 0;
      end else if (!req[m_own[n]] || (m_hold[n] == 0 && win < m_own[n])) begin
        m_own[n] = win; change = 1;
      end
      if (change) begin
        m_hold[n] = m_hold_par[n];
        m_strobes[n] = 0;
      end else if (m_busy[n] && stb) begin
        if (m_hold[n] > 0) m_hold[n]--;
        m_strobes[n]++;
      end
      if (!m_busy[n]) m_strobes[n] = 0;
    end
    e.busy = m_busy[n];
    e.gnt  = m_busy[n] ? 4'(1 << m_own[n]) : 4'b0;
    col    = rgb[3*m_own[n] +: 3];
    if (blink[m_own[n]] && ((m_strobes[n] / m_half_par[n]) % 2 == 1)) col = 3'b000;
    e.led  = m_busy[n] ? col : 3'b000;
    if (n == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input logic [3:0] rq, input logic [11:0] cl, input logic [3:0] bl,
                      input logic st, input logic rn);
    @(negedge clk);
    req = rq; rgb = cl; blink = bl; stb = st; rst_n = rn;
    model(0);
    model(1);
  endtask

  task automatic check(input int n, input exp_t e, input logic [3:0] g,
                       input logic [2:0] l, input logic bz);
    total += 3;
    if (g !== e.gnt) begin
      bad++; $display("FAIL dut%0d gnt at %0t: got=%b want=%b", n, $time, g, e.gnt);
    end
    if (l !== e.led) begin
      bad++; $display("FAIL dut%0d led at %0t: got=%b want=%b", n, $time, l, e.led);
    end
    if (bz !== e.busy) begin
      bad++; $display("FAIL dut%0d busy at %0t: got=%b want=%b", n, $time, bz, e.busy);
    end
  endtask

  // Monitor: every registered output update is matched against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check(0, q0.pop_front(), gnt0, {r0, g0, b0}, busy0);
      if (q1.size() > 0) check(1, q1.pop_front(), gnt1, {r1, g1, b1}, busy1);
    end
  end

  initial begin
    logic [3:0]  rq;
    logic [11:0] cl;
    logic [3:0]  bl;
    int          wait_cnt;

    // Reset with every requester asserted, then release.
    repeat (3) step(4'hF, 12'hFFF, 4'h0, 1'b1, 1'b0);
    step(4'hF, 12'hFFF, 4'h0, 1'b0, 1'b1);
    step(4'h0, 12'hFFF, 4'h0, 1'b0, 1'b1);

    // Single requester 2, solid 101, then drop.
    step(4'b0100, 12'h140, 4'h0, 1'b0, 1'b1);
    step(4'b0100, 12'h140, 4'h0, 1'b0, 1'b1);
    step(4'b0000, 12'h140, 4'h0, 1'b0, 1'b1);

    // Preemption after the hold expires.
    step(4'b0100, 12'h140, 4'h0, 1'b0, 1'b1);
    repeat (3) begin
      step(4'b0100, 12'h140, 4'h0, 1'b1, 1'b1);
      step(4'b0100, 12'h140, 4'h0, 1'b0, 1'b1);
    end
    repeat (8) begin
      step(4'b0101, 12'h147, 4'h0, 1'b1, 1'b1);
      step(4'b0101, 12'h147, 4'h0, 1'b0, 1'b1);
    end
    step(4'b0000, 12'h000, 4'h0, 1'b0, 1'b1);

    // Owner releases mid-hold with requester 3 pending; release lands on a strobe.
    step(4'b0001, 12'h207, 4'h0, 1'b0, 1'b1);
    step(4'b1001, 12'h207, 4'h0, 1'b1, 1'b1);
    step(4'b1001, 12'h207, 4'h0, 1'b0, 1'b1);
    step(4'b1000, 12'h207, 4'h0, 1'b1, 1'b1);
    step(4'b1000, 12'h207, 4'h0, 1'b0, 1'b1);
    step(4'b0000, 12'h207, 4'h0, 1'b0, 1'b1);

    // Blink on requester 1 with green only.
    for (int i = 0; i < 40; i++) step(4'b0010, 12'h010, 4'b0010, 1'(i % 2), 1'b1);
    step(4'b0000, 12'h010, 4'b0010, 1'b0, 1'b1);

    // Randomised traffic.
    rq = 4'b0110; cl = 12'h5A3; bl = 4'b1010;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) cl = 12'($urandom);
      if ($urandom_range(0, 31) == 0) bl = 4'($urandom_range(0, 15));
      step(rq, cl, bl, ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) != 0));
    end

    wait_cnt = 0;
    while ((q0.size() > 0 || q1.size() > 0) && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d/%0d pending want=0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
